// File: rtl/gsm_bus_arbiter_if.sv
// Common write bus bundle for the GSM bus arbiter.
// Requesters/back-pressure in, one-hot select and burst framing out.
interface gsm_bus_arbiter_if #(
  parameter int MWIDTH     = 4,
  parameter int LOG_MWIDTH = 2,
  parameter int CWIDTH     = 3
);

  logic [MWIDTH-1:0]        i_req;
  logic                     i_stall;
  logic [MWIDTH-1:0]        o_sel;
  logic [LOG_MWIDTH-1:0]    o_grant_idx;
  logic                     o_sof;
  logic                     o_eof;
  logic                     o_busy;
  logic [MWIDTH*CWIDTH-1:0] o_pending_cnt;
  logic [MWIDTH-1:0]        o_overflow;

  modport master (
    output i_req,
    output i_stall,
    input  o_sel,
    input  o_grant_idx,
    input  o_sof,
    input  o_eof,
    input  o_busy,
    input  o_pending_cnt,
    input  o_overflow
  );

  modport slave (
    input  i_req,
    input  i_stall,
    output o_sel,
    output o_grant_idx,
    output o_sof,
    output o_eof,
    output o_busy,
    output o_pending_cnt,
    output o_overflow
  );

endinterface

// File: rtl/gsm_bus_arbiter.sv
// Round-robin burst scheduler for the 320 MHz common write bus.
// Counts pending cells per port; back-pressure honoured at burst boundaries.
module gsm_bus_arbiter #(
  parameter int MWIDTH     = 4,
  parameter int LOG_MWIDTH = 2,
  parameter int CWIDTH     = 3,
  parameter int BURST_LEN  = 1
) (
  input  logic clk_320M,
  input  logic rst_n,
  input  logic clr_320M,
  gsm_bus_arbiter_if.slave bus
);

  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BW-1:0] LAST = BW'(BURST_LEN - 1);
  localparam logic [CWIDTH-1:0] CMAX = '1;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t                state_q, state_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic [LOG_MWIDTH-1:0] ptr_q, ptr_d;
  logic [LOG_MWIDTH-1:0] idx_q, idx_d;
  logic [LOG_MWIDTH-1:0] win;
  logic [MWIDTH-1:0]     sel_q, sel_d;
  logic                  sof_q, sof_d;
  logic                  eof_q, eof_d;
  logic [MWIDTH-1:0]     elig;
  logic [MWIDTH-1:0]     dec;
  logic [MWIDTH-1:0]     ovf_q;
  logic [CWIDTH-1:0]     cnt_q [MWIDTH];
  logic                  found;
  logic                  decision;
  logic                  grant;
  int unsigned           cand;

  // Eligibility uses registered counts only.
  always_comb begin
    for (int i = 0; i < MWIDTH; i++) begin
      elig[i] = (cnt_q[i] != '0);
    end
  end

  // Round-robin search starting at the pointer; first eligible wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = 0;
    for (int j = 0; j < MWIDTH; j++) begin
      cand = (int'(ptr_q) + j) % MWIDTH;
      if (!found && elig[cand]) begin
        found = 1'b1;
        win   = LOG_MWIDTH'(cand);
      end
    end
  end

  // Grant only at burst boundaries when not back-pressured.
  always_comb begin
    decision = (state_q == IDLE) || (beat_q == LAST);
    grant    = decision && found && !bus.i_stall;
    dec      = grant ? (MWIDTH'(1) << win) : '0;
  end

  // Next-state, beat, pointer and registered bus outputs.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    unique case (1'b1)
      grant: begin
        state_d = BUSY;
        beat_d  = '0;
        sel_d   = MWIDTH'(1) << win;
        idx_d   = win;
        ptr_d   = LOG_MWIDTH'((int'(win) + 1) % MWIDTH);
      end
      (decision && !grant): begin
        state_d = IDLE;
        beat_d  = '0;
        sel_d   = '0;
      end
      (!decision): begin
        beat_d = beat_q + 1'b1;
      end
      default: ;
    endcase
    sof_d = (state_d == BUSY) && (beat_d == '0);
    eof_d = (state_d == BUSY) && (beat_d == LAST);
  end

  // State register; reset drops the select immediately.
  always_ff @(posedge clk_320M or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      ptr_q   <= '0;
      idx_q   <= '0;
      sel_q   <= '0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
    end else if (clr_320M) begin
      state_q <= IDLE;
      beat_q  <= '0;
      ptr_q   <= '0;
      idx_q   <= '0;
      sel_q   <= '0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      sof_q   <= sof_d;
      eof_q   <= eof_d;
    end
  end

  // Pending-cell counters: saturate high with sticky overflow.
  always_ff @(posedge clk_320M or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MWIDTH; i++) begin
        cnt_q[i] <= '0;
      end
      ovf_q <= '0;
    end else if (clr_320M) begin
      for (int i = 0; i < MWIDTH; i++) begin
        cnt_q[i] <= '0;
      end
      ovf_q <= '0;
    end else begin
      for (int i = 0; i < MWIDTH; i++) begin
        if (bus.i_req[i] && !dec[i]) begin
          if (cnt_q[i] == CMAX) begin
            ovf_q[i] <= 1'b1;
          end else begin
            cnt_q[i] <= cnt_q[i] + 1'b1;
          end
        end else if (!bus.i_req[i] && dec[i]) begin
          cnt_q[i] <= cnt_q[i] - 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < MWIDTH; g++) begin : g_pack
    assign bus.o_pending_cnt[g*CWIDTH +: CWIDTH] = cnt_q[g];
  end

  assign bus.o_sel       = sel_q;
  assign bus.o_grant_idx = idx_q;
  assign bus.o_sof       = sof_q;
  assign bus.o_eof       = eof_q;
  assign bus.o_busy      = (state_q == BUSY);
  assign bus.o_overflow  = ovf_q;

endmodule

// File: tb/tb_gsm_bus_arbiter.sv
// Bench for gsm_bus_arbiter: a 4-beat instance and a 1-beat instance.
// Grants are scoreboarded in order against queued expectations.
`timescale 1ns/1ps
module tb_gsm_bus_arbiter;

  logic clk_320M = 1'b0;
  logic rst_n    = 1'b0;
  logic clr_320M = 1'b0;

  always #2 clk_320M = ~clk_320M;

  gsm_bus_arbiter_if #(.MWIDTH(4), .LOG_MWIDTH(2), .CWIDTH(3)) ifa ();
  gsm_bus_arbiter_if #(.MWIDTH(4), .LOG_MWIDTH(2), .CWIDTH(3)) ifb ();

  gsm_bus_arbiter #(
    .MWIDTH(4), .LOG_MWIDTH(2), .CWIDTH(3), .BURST_LEN(4)
  ) u_a (
    .clk_320M(clk_320M),
    .rst_n(rst_n),
    .clr_320M(clr_320M),
    .bus(ifa)
  );

  gsm_bus_arbiter #(
    .MWIDTH(4), .LOG_MWIDTH(2), .CWIDTH(3), .BURST_LEN(1)
  ) u_b (
    .clk_320M(clk_320M),
    .rst_n(rst_n),
    .clr_320M(clr_320M),
    .bus(ifb)
  );

  int nchecks = 0;
  int nfail   = 0;
  int qa[$];
  int qb[$];

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    nchecks++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_320M);
    #1;
  endtask

  function automatic logic [2:0] cnt_of(logic [11:0] v, int i);
    return v[i*3 +: 3];
  endfunction

  task automatic wait_idle_a(int budget);
    int n;
    n = 0;
    while ((qa.size() != 0 || ifa.o_busy) && n < budget) begin
      tick();
      n++;
    end
    check("a_drain", 32'(qa.size() == 0 && !ifa.o_busy), 1);
  endtask

  // Scoreboard for instance A: each burst start pops one expectation.
  always @(posedge clk_320M) begin
    int e;
    #1;
    if (rst_n) begin
      check("a_onehot", 32'($onehot0(ifa.o_sel)), 1);
      if (ifa.o_sof) begin
        if (qa.size() == 0) begin
          check("a_unexpected_grant", 32'(ifa.o_grant_idx), 32'hff);
        end else begin
          e = qa.pop_front();
          check("a_grant_idx", 32'(ifa.o_grant_idx), e);
          check("a_grant_sel", 32'(ifa.o_sel), 32'(1) << e);
        end
      end
    end
  end

  // Scoreboard for instance B.
  always @(posedge clk_320M) begin
    int e;
    #1;
    if (rst_n && ifb.o_sof) begin
      if (qb.size() == 0) begin
        check("b_unexpected_grant", 32'(ifb.o_grant_idx), 32'hff);
      end else begin
        e = qb.pop_front();
        check("b_grant_idx", 32'(ifb.o_grant_idx), e);
      end
    end
  end

  initial begin
    ifa.i_req   = '0;
    ifa.i_stall = 1'b0;
    ifb.i_req   = '0;
    ifb.i_stall = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    check("rst_sel", 32'(ifa.o_sel), 0);
    check("rst_busy", 32'(ifa.o_busy), 0);
    check("rst_sof", 32'(ifa.o_sof), 0);
    check("rst_idx", 32'(ifa.o_grant_idx), 0);
    check("rst_pend", 32'(ifa.o_pending_cnt), 0);
    check("rst_ovf", 32'(ifa.o_overflow), 0);
    check("rst_b_pend", 32'(ifb.o_pending_cnt), 0);

    // T2: all four ports at once on the single-beat instance
    ifb.i_req = 4'b1111;
    for (int k = 0; k < 4; k++) qb.push_back(k);
    tick();
    ifb.i_req = '0;
    check("t2_cnt_all", 32'(ifb.o_pending_cnt), 32'h249);
    check("t2_sel_pre", 32'(ifb.o_sel), 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t2_sel", 32'(ifb.o_sel), 32'(1) << k);
      check("t2_sof", 32'(ifb.o_sof), 1);
      check("t2_eof", 32'(ifb.o_eof), 1);
      check("t2_busy", 32'(ifb.o_busy), 1);
    end
    tick();
    check("t2_sel_end", 32'(ifb.o_sel), 0);
    check("t2_busy_end", 32'(ifb.o_busy), 0);
    check("t2_pend_end", 32'(ifb.o_pending_cnt), 0);

    // T1: single port-2 cell, four beats
    ifa.i_req = 4'b0100;
    qa.push_back(2);
    tick();
    ifa.i_req = '0;
    check("t1_cnt2", 32'(cnt_of(ifa.o_pending_cnt, 2)), 1);
    check("t1_sel_pre", 32'(ifa.o_sel), 0);
    for (int b = 0; b < 4; b++) begin
      tick();
      check("t1_sel", 32'(ifa.o_sel), 4'b0100);
      check("t1_sof", 32'(ifa.o_sof), 32'(b == 0));
      check("t1_eof", 32'(ifa.o_eof), 32'(b == 3));
      check("t1_busy", 32'(ifa.o_busy), 1);
      if (b == 0) check("t1_cnt2_dec", 32'(cnt_of(ifa.o_pending_cnt, 2)), 0);
    end
    tick();
    check("t1_sel_end", 32'(ifa.o_sel), 0);
    check("t1_busy_end", 32'(ifa.o_busy), 0);

    // T3: fairness from pointer 0, port 0 streaming, port 3 one pulse
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    qa.push_back(0);
    qa.push_back(3);
    for (int k = 0; k < 5; k++) qa.push_back(0);
    ifa.i_req = 4'b0001;
    tick();
    tick();
    ifa.i_req = 4'b1001;
    tick();
    ifa.i_req = 4'b0001;
    tick();
    tick();
    tick();
    ifa.i_req = '0;
    wait_idle_a(200);
    check("t3_pend_end", 32'(ifa.o_pending_cnt), 0);

    // T4: stall blocks starting, never truncates a burst
    ifa.i_stall = 1'b1;
    ifa.i_req   = 4'b0010;
    tick();
    tick();
    ifa.i_req = '0;
    tick();
    tick();
    check("t4_sel_stalled", 32'(ifa.o_sel), 0);
    check("t4_cnt1", 32'(cnt_of(ifa.o_pending_cnt, 1)), 2);
    qa.push_back(1);
    qa.push_back(1);
    ifa.i_stall = 1'b0;
    tick();
    check("t4_sel_go", 32'(ifa.o_sel), 4'b0010);
    ifa.i_stall = 1'b1;
    tick();
    tick();
    tick();
    check("t4_eof", 32'(ifa.o_eof), 1);
    check("t4_sel_last", 32'(ifa.o_sel), 4'b0010);
    tick();
    check("t4_sel_held_off", 32'(ifa.o_sel), 0);
    check("t4_busy_off", 32'(ifa.o_busy), 0);
    check("t4_cnt1_left", 32'(cnt_of(ifa.o_pending_cnt, 1)), 1);
    ifa.i_stall = 1'b0;
    tick();
    check("t4_sel_resume", 32'(ifa.o_sel), 4'b0010);
    wait_idle_a(100);

    // T5: saturation and sticky overflow, then exactly seven bursts
    ifa.i_stall = 1'b1;
    ifa.i_req   = 4'b0001;
    repeat (8) tick();
    ifa.i_req = '0;
    tick();
    check("t5_cnt0_sat", 32'(cnt_of(ifa.o_pending_cnt, 0)), 7);
    check("t5_ovf", 32'(ifa.o_overflow), 4'b0001);
    for (int k = 0; k < 7; k++) qa.push_back(0);
    ifa.i_stall = 1'b0;
    wait_idle_a(200);
    tick();
    check("t5_ovf_sticky", 32'(ifa.o_overflow), 4'b0001);
    check("t5_pend_end", 32'(ifa.o_pending_cnt), 0);
    check("t5_no_extra", 32'(ifa.o_busy), 0);

    // T6a: async reset during beat 2
    ifa.i_req = 4'b0110;
    qa.push_back(1);
    tick();
    ifa.i_req = '0;
    tick();
    check("t6_sel_start", 32'(ifa.o_sel), 4'b0010);
    tick();
    tick();
    check("t6_beat2_sof", 32'(ifa.o_sof), 0);
    check("t6_beat2_eof", 32'(ifa.o_eof), 0);
    rst_n = 1'b0;
    #1;
    check("t6_rst_sel", 32'(ifa.o_sel), 0);
    check("t6_rst_busy", 32'(ifa.o_busy), 0);
    check("t6_rst_pend", 32'(ifa.o_pending_cnt), 0);
    check("t6_rst_ovf", 32'(ifa.o_overflow), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // T6b: synchronous clear mid-burst
    ifa.i_stall = 1'b1;
    ifa.i_req   = 4'b1000;
    repeat (8) tick();
    ifa.i_req = '0;
    check("t6_ovf3", 32'(ifa.o_overflow), 4'b1000);
    check("t6_cnt3", 32'(cnt_of(ifa.o_pending_cnt, 3)), 7);
    qa.push_back(3);
    ifa.i_stall = 1'b0;
    tick();
    check("t6_sel3", 32'(ifa.o_sel), 4'b1000);
    tick();
    clr_320M = 1'b1;
    tick();
    clr_320M = 1'b0;
    check("t6_clr_sel", 32'(ifa.o_sel), 0);
    check("t6_clr_busy", 32'(ifa.o_busy), 0);
    check("t6_clr_pend", 32'(ifa.o_pending_cnt), 0);
    check("t6_clr_ovf", 32'(ifa.o_overflow), 0);
    tick();
    check("t6_clr_quiet", 32'(ifa.o_sel), 0);

    check("qa_empty", 32'(qa.size()), 0);
    check("qb_empty", 32'(qb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end

endmodule
